imem_loader: RTL and testbench

- Boot-time program loader: the writer side of the instruction memory that the 16-bit CPU fetches from.
- Accepts a framed byte stream (host link/UART byte FIFO) over a valid/ready handshake.
- Packs bytes into big-endian 16-bit instruction words and writes them to Imem starting at address 0.
- Holds the CPU in reset until a complete frame with a valid checksum is loaded.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/imem_loader_if.sv | 9 +
 rtl/imem_loader.sv | 135 +++++++++++++
 tb/tb_imem_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Definitions shared by the CPU and its boot-time program loader:
// loader state encoding, frame layout and instruction memory geometry.
package cpu_pkg;

  localparam int INSTR_W     = 16;
  localparam int IMEM_ADDR_W = 10;

  // Frame layout: big-endian word count, payload words, trailing XOR byte
  localparam int LEN_BYTES = 2;
  localparam int CHK_BYTES = 1;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LEN_HI,
    LD_LEN_LO,
    LD_DATA_HI,
    LD_DATA_LO,
    LD_CHECK,
    LD_DONE,
    LD_ERR
  } ld_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready link feeding the program loader.
interface imem_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// Boot loader: unpacks a length/payload/XOR frame from a byte stream into
// instruction memory and releases the CPU once the checksum matches.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int MAX_WORDS = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  imem_loader_if.slave        bus,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [INSTR_W-1:0]  imem_wdata,
  output logic                cpu_hold,
  output logic                done,
  output logic                err,
  output logic [ADDR_W:0]     words_loaded
);

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  ld_state_t       state;
  logic [7:0]      hi_byte;
  logic [7:0]      acc;
  logic [ADDR_W:0] len;
  logic [ADDR_W:0] word_idx;
  logic            xfer;
  logic [15:0]     len_full;

  assign xfer     = bus.in_valid & bus.in_ready;
  assign len_full = {hi_byte, bus.in_data};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= LD_IDLE;
      bus.in_ready <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      acc          <= '0;
      hi_byte      <= '0;
      len          <= '0;
      word_idx     <= '0;
    end else begin
      imem_we <= 1'b0;
      // The count trails the write strobe by one cycle
      if (imem_we) words_loaded <= words_loaded + CNT_ONE;

      case (state)
        LD_IDLE, LD_DONE, LD_ERR: begin
          if (start) begin
            state        <= LD_LEN_HI;
            bus.in_ready <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            cpu_hold     <= 1'b1;
            words_loaded <= '0;
            acc          <= '0;
            word_idx     <= '0;
          end
        end

        LD_LEN_HI: begin
          if (xfer) begin
            hi_byte <= bus.in_data;
            acc     <= acc ^ bus.in_data;
            state   <= LD_LEN_LO;
          end
        end

        LD_LEN_LO: begin
          if (xfer) begin
            acc <= acc ^ bus.in_data;
            len <= len_full[ADDR_W:0];
            // Oversized frames are refused before any payload is consumed
            if ({16'd0, len_full} > 32'(MAX_WORDS)) begin
              state        <= LD_ERR;
              err          <= 1'b1;
              bus.in_ready <= 1'b0;
            end else if (len_full == 16'd0) begin
              state <= LD_CHECK;
            end else begin
              state <= LD_DATA_HI;
            end
          end
        end

        LD_DATA_HI: begin
          if (xfer) begin
            hi_byte <= bus.in_data;
            acc     <= acc ^ bus.in_data;
            state   <= LD_DATA_LO;
          end
        end

        LD_DATA_LO: begin
          if (xfer) begin
            acc        <= acc ^ bus.in_data;
            imem_we    <= 1'b1;
            imem_addr  <= word_idx[ADDR_W-1:0];
            imem_wdata <= {hi_byte, bus.in_data};
            word_idx   <= word_idx + CNT_ONE;
            state      <= (word_idx + CNT_ONE == len) ? LD_CHECK : LD_DATA_HI;
          end
        end

        LD_CHECK: begin
          if (xfer) begin
            bus.in_ready <= 1'b0;
            if (bus.in_data == acc) begin
              state    <= LD_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= LD_ERR;
              err   <= 1'b1;
            end
          end
        end

        default: begin
          state        <= LD_IDLE;
          bus.in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized frames for the program loader, checked against a
// frame-level model: expected writes are the payload words at 0..N-1.
module tb_imem_loader;
  import cpu_pkg::*;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1024;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic                imem_we;
  logic [ADDR_W-1:0]   imem_addr;
  logic [INSTR_W-1:0]  imem_wdata;
  logic                cpu_hold;
  logic                done;
  logic                err;
  logic [ADDR_W:0]     words_loaded;

  imem_loader_if bus();

  imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int got_addr[$];
  int got_data[$];
  bit gap_mode = 1'b0;

  always @(negedge clk) begin
    if (imem_we) begin
      got_addr.push_back(int'(imem_addr));
      got_data.push_back(int'(imem_wdata));
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    bit ok;
    n = 0;
    if (gap_mode) begin
      repeat ($urandom_range(0, 2)) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    do begin
      ok = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 50);
    bus.in_valid = 1'b0;
    if (!ok) check("in_ready_timeout", 0, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [15:0] n,
                           input logic [15:0] words[$], input bit corrupt);
    logic [7:0] bytes[$];
    logic [7:0] chk;
    bit         good;
    bytes.delete();
    bytes.push_back(n[15:8]);
    bytes.push_back(n[7:0]);
    foreach (words[i]) begin
      bytes.push_back(words[i][15:8]);
      bytes.push_back(words[i][7:0]);
    end
    chk = 8'h00;
    foreach (bytes[i]) chk = chk ^ bytes[i];
    if (corrupt) chk = chk ^ 8'h5A;
    good = !corrupt;

    got_addr.delete();
    got_data.delete();
    pulse_start();
    check({tag, "_hold_at_start"}, int'(cpu_hold), 1);
    check({tag, "_ready_at_start"}, int'(bus.in_ready), 1);
    check({tag, "_flags_cleared"}, int'({done, err}), 0);
    check({tag, "_count_cleared"}, int'(words_loaded), 0);

    if (int'(n) > MAX_WORDS) begin
      send_byte(bytes[0]);
      send_byte(bytes[1]);
      check({tag, "_err"}, int'(err), 1);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_hold"}, int'(cpu_hold), 1);
      repeat (3) begin
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      check({tag, "_ready_low"}, int'(bus.in_ready), 0);
      check({tag, "_no_writes"}, got_addr.size(), 0);
      check({tag, "_count"}, int'(words_loaded), 0);
      return;
    end

    foreach (bytes[i]) send_byte(bytes[i]);
    check({tag, "_not_done_before_chk"}, int'(done), 0);
    send_byte(chk);
    check({tag, "_done"}, int'(done), int'(good));
    check({tag, "_err"}, int'(err), int'(!good));
    check({tag, "_hold"}, int'(cpu_hold), int'(!good));
    check({tag, "_ready_after"}, int'(bus.in_ready), 0);
    check({tag, "_count"}, int'(words_loaded), int'(n));
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_write_count"}, got_addr.size(), int'(n));
    for (int i = 0; i < got_addr.size() && i < int'(n); i++) begin
      if (got_addr[i] !== i || got_data[i] !== int'(words[i]))
        begin
          check({tag, "_wr_addr"}, got_addr[i], i);
          check({tag, "_wr_data"}, got_data[i], int'(words[i]));
        end
    end
    // One summary comparison over all writes keeps the count readable
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < got_addr.size() && i < int'(n); i++)
        if (got_addr[i] !== i || got_data[i] !== int'(words[i])) bad++;
      check({tag, "_writes_match"}, bad, 0);
    end
  endtask

  initial begin
    logic [15:0] w[$];
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", int'(bus.in_ready), 0);
    check("rst_we", int'(imem_we), 0);
    check("rst_addr", int'(imem_addr), 0);
    check("rst_wdata", int'(imem_wdata), 0);
    check("rst_hold", int'(cpu_hold), 1);
    check("rst_flags", int'({done, err}), 0);
    check("rst_count", int'(words_loaded), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", int'(bus.in_ready), 0);

    // Basic three-word frame, back-to-back bytes
    w = '{16'h0123, 16'h4567, 16'h89AB};
    gap_mode = 1'b0;
    run_frame("n3", 16'd3, w, 1'b0);

    // Same frame with in_valid gaps
    gap_mode = 1'b1;
    run_frame("n3_gaps", 16'd3, w, 1'b0);

    // Empty frame
    gap_mode = 1'b0;
    w.delete();
    run_frame("n0", 16'd0, w, 1'b0);

    // Corrupted checksum
    w = '{16'hDEAD, 16'hBEEF};
    run_frame("n2_badchk", 16'd2, w, 1'b1);

    // Oversized length is refused at LEN_LO
    w.delete();
    run_frame("n401", 16'h0401, w, 1'b0);

    // Reset after the first word of a four-word frame
    got_addr.delete();
    got_data.delete();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h04);
    send_byte(8'h11);
    send_byte(8'h22);
    check("mid_we_pulse", int'(imem_we), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("mid_rst_ready", int'(bus.in_ready), 0);
    check("mid_rst_we", int'(imem_we), 0);
    check("mid_rst_addr", int'(imem_addr), 0);
    check("mid_rst_wdata", int'(imem_wdata), 0);
    check("mid_rst_hold", int'(cpu_hold), 1);
    check("mid_rst_flags", int'({done, err}), 0);
    check("mid_rst_count", int'(words_loaded), 0);
    w = '{16'h1122, 16'h3344, 16'h5566, 16'h7788};
    run_frame("after_rst", 16'd4, w, 1'b0);

    // Largest accepted frame
    w.delete();
    for (int i = 0; i < MAX_WORDS; i++) w.push_back(16'($urandom));
    run_frame("n_max", 16'(MAX_WORDS), w, 1'b0);

    // Randomized frames
    for (int t = 0; t < 8; t++) begin
      int n;
      bit bad;
      n = $urandom_range(1, 12);
      w.delete();
      for (int i = 0; i < n; i++) w.push_back(16'($urandom));
      bad = ($urandom_range(0, 3) == 0);
      gap_mode = bit'($urandom_range(0, 1));
      run_frame($sformatf("rand%0d", t), 16'(n), w, bad);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
